fetch_stage: RTL and testbench

- Instruction fetch stage directly upstream of instruction memory.
- Owns the program counter and drives the word-aligned read address into the combinational-read instruction memory.
- Captures the returned instruction into the IF/ID pipeline register and presents it to decode with a valid/ready handshake.
- Handles stalls, branch/jump redirects with flush, and halt.

---
 rtl/cpu_defs_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding, fetch FSM states and IF/ID payload.
package cpu_defs_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load/flush/drain controls; reset and flush leave a NOP behind.
module if_id_reg
  import cpu_defs_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  logic   drain,
  input  if_id_t d,
  output logic   valid,
  output if_id_t q
);

  // Priority: reset, flush, load, drain (consume without replacing), hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= 1'b0;
      q.instr    <= NOP_INSTR;
      q.pc       <= '0;
      q.pc_plus4 <= '0;
    end else if (flush) begin
      valid   <= 1'b0;
      q.instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, redirect/halt FSM and IF/ID handoff to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage
  import cpu_defs_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            halted,
  output logic            fetch_fault
);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            halted_next, fault_next;
  logic            ifid_load, ifid_flush, ifid_drain;
  logic            adv;
  if_id_t          ifid_d, ifid_q;

  // pc may hold a raw misaligned target for debug; memory only ever sees a word address.
  assign imem_addr = {pc[XLEN-1:2], 2'b00};

  assign adv = (state == ST_RUN) && (!id_valid || id_ready);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    fault_next = fetch_fault;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_drain = 1'b0;
    case (state)
      ST_RUN: begin
        if (redirect_valid) begin
          ifid_flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
          pc_next = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) begin
            state_next = ST_FAULT;
            fault_next = 1'b1;
          end
`else
          pc_next = {redirect_pc[XLEN-1:2], 2'b00};
`endif
        end else if (halt_req) begin
          state_next = ST_HALTED;
          ifid_drain = id_valid && id_ready;
        end else if (adv) begin
          ifid_load = 1'b1;
          pc_next   = pc + PC_INC;
        end
      end
      default: ifid_drain = id_valid && id_ready;
    endcase
    halted_next = (state_next != ST_RUN);
  end

`ifndef FETCH_ALIGN_CHECK_EN
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      pc          <= RESET_PC;
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      halted      <= halted_next;
      fetch_fault <= fault_next;
    end
  end

  assign ifid_d.instr    = imem_instr;
  assign ifid_d.pc       = pc;
  assign ifid_d.pc_plus4 = pc + PC_INC;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .drain (ifid_drain),
    .d     (ifid_d),
    .valid (id_valid),
    .q     (ifid_q)
  );

  assign id_instr    = ifid_q.instr;
  assign id_pc       = ifid_q.pc;
  assign id_pc_plus4 = ifid_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus a misaligned-redirect sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int NV = 28;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_instr, redirect_pc, id_instr, id_pc, id_pc_plus4;
  logic        redirect_valid, halt_req, id_valid, id_ready, halted, fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0010_0093 : (32'hA500_0000 ^ a);
  endfunction

  assign imem_instr = mem_at(imem_addr);

  fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .halted(halted), .fetch_fault(fetch_fault)
  );

  typedef struct {
    logic        rst, rv;
    logic [31:0] rpc;
    logic        hr, rdy;
    logic        ev;
    logic [31:0] ei, ep, ep4, ea;
    logic        eh;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic rst, rv, input logic [31:0] rpc, input logic hr, rdy,
                              input logic ev, input logic [31:0] ei, ep, ep4, ea, input logic eh);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.hr = hr; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ep4 = ep4; v.ea = ea; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL step %0d %s: got %h expected %h", step, name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, rv, input logic [31:0] rpc, input logic hr, rdy);
    reset = rst; redirect_valid = rv; redirect_pc = rpc; halt_req = hr; id_ready = rdy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

    //           rst rv  rpc           hr  rdy  ev  instr                   pc            pc+4          addr          halted
    vecs[0]  = mk(1, 0, 32'h0,        0,  0,   0,  NOP,                    32'h0,        32'h0,        32'h0,        0);
    vecs[1]  = mk(1, 0, 32'h0,        0,  1,   0,  NOP,                    32'h0,        32'h0,        32'h0,        0);
    vecs[2]  = mk(0, 0, 32'h0,        0,  1,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        0);
    vecs[3]  = mk(0, 0, 32'h0,        0,  1,   1,  mem_at(32'h4),          32'h4,        32'h8,        32'h8,        0);
    vecs[4]  = mk(0, 0, 32'h0,        0,  1,   1,  mem_at(32'h8),          32'h8,        32'hC,        32'hC,        0);
    vecs[5]  = mk(0, 0, 32'h0,        0,  0,   1,  mem_at(32'h8),          32'h8,        32'hC,        32'hC,        0);
    vecs[6]  = mk(0, 0, 32'h0,        0,  0,   1,  mem_at(32'h8),          32'h8,        32'hC,        32'hC,        0);
    vecs[7]  = mk(0, 0, 32'h0,        0,  0,   1,  mem_at(32'h8),          32'h8,        32'hC,        32'hC,        0);
    vecs[8]  = mk(0, 0, 32'h0,        0,  1,   1,  mem_at(32'hC),          32'hC,        32'h10,       32'h10,       0);
    vecs[9]  = mk(0, 1, 32'h40,       0,  0,   0,  NOP,                    32'hC,        32'h10,       32'h40,       0);
    vecs[10] = mk(0, 0, 32'h0,        0,  0,   1,  mem_at(32'h40),         32'h40,       32'h44,       32'h44,       0);
    vecs[11] = mk(0, 0, 32'h0,        0,  1,   1,  mem_at(32'h44),         32'h44,       32'h48,       32'h48,       0);
    vecs[12] = mk(0, 1, 32'hFFFF_FFFC,0,  1,   0,  NOP,                    32'h44,       32'h48,       32'hFFFF_FFFC,0);
    vecs[13] = mk(0, 0, 32'h0,        0,  1,   1,  mem_at(32'hFFFF_FFFC),  32'hFFFF_FFFC,32'h0,        32'h0,        0);
    vecs[14] = mk(0, 0, 32'h0,        0,  1,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        0);
    vecs[15] = mk(0, 0, 32'h0,        0,  0,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        0);
    vecs[16] = mk(1, 0, 32'h0,        0,  0,   0,  NOP,                    32'h0,        32'h0,        32'h0,        0);
    vecs[17] = mk(0, 0, 32'h0,        0,  1,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        0);
    vecs[18] = mk(0, 1, 32'h80,       1,  0,   0,  NOP,                    32'h0,        32'h4,        32'h80,       0);
    vecs[19] = mk(0, 0, 32'h0,        1,  0,   0,  NOP,                    32'h0,        32'h4,        32'h80,       1);
    vecs[20] = mk(1, 0, 32'h0,        0,  0,   0,  NOP,                    32'h0,        32'h0,        32'h0,        0);
    vecs[21] = mk(0, 0, 32'h0,        0,  0,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        0);
    vecs[22] = mk(0, 0, 32'h0,        1,  0,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        1);
    vecs[23] = mk(0, 0, 32'h0,        0,  0,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        1);
    vecs[24] = mk(0, 0, 32'h0,        0,  1,   0,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        1);
    vecs[25] = mk(0, 1, 32'h100,      1,  1,   0,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        1);
    vecs[26] = mk(1, 0, 32'h0,        0,  1,   0,  NOP,                    32'h0,        32'h0,        32'h0,        0);
    vecs[27] = mk(0, 0, 32'h0,        0,  1,   1,  32'h0010_0093,          32'h0,        32'h4,        32'h4,        0);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].hr, vecs[i].rdy);
      @(posedge clk);
      @(negedge clk);
      chk("id_valid", i, 32'(id_valid), 32'(vecs[i].ev));
      chk("id_instr", i, id_instr, vecs[i].ei);
      chk("id_pc", i, id_pc, vecs[i].ep);
      chk("id_pc_plus4", i, id_pc_plus4, vecs[i].ep4);
      chk("imem_addr", i, imem_addr, vecs[i].ea);
      chk("halted", i, 32'(halted), 32'(vecs[i].eh));
      chk("fetch_fault", i, 32'(fetch_fault), 32'h0);
    end

    // Misaligned redirect to 0x42 from a running pipeline.
    drive(1'b0, 1'b1, 32'h0000_0042, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("mis_valid", 100, 32'(id_valid), 32'h0);
    chk("mis_addr", 100, imem_addr, 32'h40);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", 100, 32'(fetch_fault), 32'h1);
    chk("mis_halted", 100, 32'(halted), 32'h1);
    for (int k = 1; k <= 2; k++) begin
      drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b1);
      @(posedge clk); @(negedge clk);
      chk("fault_hold", 100 + k, 32'(fetch_fault), 32'h1);
      chk("fault_valid", 100 + k, 32'(id_valid), 32'h0);
      chk("fault_halted", 100 + k, 32'(halted), 32'h1);
      chk("fault_addr", 100 + k, imem_addr, 32'h40);
    end
`else
    chk("mis_fault", 100, 32'(fetch_fault), 32'h0);
    chk("mis_halted", 100, 32'(halted), 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("mis_next_valid", 101, 32'(id_valid), 32'h1);
    chk("mis_next_pc", 101, id_pc, 32'h40);
    chk("mis_next_instr", 101, id_instr, mem_at(32'h40));
    chk("mis_next_addr", 101, imem_addr, 32'h44);
`endif

    // Reset clears any terminal state.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("rst_fault", 200, 32'(fetch_fault), 32'h0);
    chk("rst_halted", 200, 32'(halted), 32'h0);
    chk("rst_valid", 200, 32'(id_valid), 32'h0);
    chk("rst_instr", 200, id_instr, NOP);
    chk("rst_addr", 200, imem_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
